hcsr04_ranger: RTL and testbench
================================

# hcsr04_ranger

Measurement sequencer for the HC-SR04 ultrasonic sensor. Generates the trigger pulse, times the echo pulse, converts it directly to centimetres, handles missing or over-long echoes, and enforces the sensor's recovery interval between shots. Sits between the sensor pins and application logic (display, LED, proximity FSM), and serves single-shot or free-running requests.

## Interface
- `TRIG_CYCLES`, default 500: trigger high time in clk cycles (10 µs @ 50 MHz)
- `CYCLES_PER_CM`, default 2900: clk cycles of echo per 1 cm (58 µs @ 50 MHz)
- `ECHO_WAIT_CYCLES`, default 1_500_000: maximum wait for echo rise (30 ms)
- `COOLDOWN_CYCLES`, default 3_000_000: echo-low dwell before the next shot (60 ms)
- `MAX_CM`, default 400: saturation / overrange distance
- `NEAR_CM`, default 20: proximity threshold
- `DIST_W`, default 9: distance width; must hold `MAX_CM`
- `clk`, in, 1: system clock, the only clock
- `rst`, in, 1: synchronous, active-high reset
- `Start`, in, 1: single-shot request, sampled in IDLE only
- `Auto`, in, 1: free-running mode; a new shot starts whenever IDLE is entered with Auto=1
- `Echo`, in, 1: raw sensor echo, asynchronous
- `Trigger`, out, 1: sensor trigger pulse (registered)
- `Busy`, out, 1: high in every state except IDLE
- `Done`, out, 1: one-cycle pulse marking a result
- `Distance`, out, DIST_W: last result in cm, held between Done pulses
- `Timeout`, out, 1: last result was no-echo or overrange; held with Distance
- `Near`, out, 1: `Distance < NEAR_CM` and `!Timeout`; updated with Done (LED drive)

## Operation
- Echo passes through a 2-FF synchronizer, then a rise/fall detector on the synchronized level. This adds 2 cycles of latency, which is fixed and accepted.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, COOLDOWN.
- IDLE: if `Start | Auto`, go to TRIG. Clear the cycle and cm counters.
- TRIG: `Trigger`=1 for exactly `TRIG_CYCLES` cycles, then go to WAIT_RISE.
- WAIT_RISE: a synchronized rising edge moves to MEASURE and clears the sub-cm counter.
  - A rising edge is required. Echo already high on entry does not count.
  - After `ECHO_WAIT_CYCLES` with no edge: Done, Timeout=1, Distance=`MAX_CM`, go to COOLDOWN.
- MEASURE: the sub-cm counter wraps at `CYCLES_PER_CM` and increments the cm count at each wrap.
  - Synchronized falling edge: Done, Distance=cm count (remainder truncated), Timeout=0, go to COOLDOWN.
  - cm count reaches `MAX_CM` before the fall: Done, Distance=`MAX_CM`, Timeout=1, go to COOLDOWN without waiting for the fall.
- COOLDOWN: the counter runs only while synchronized Echo=0 and restarts if Echo goes high. After `COOLDOWN_CYCLES` consecutive low cycles, go to IDLE.
- Start while Busy is ignored; there is no queuing. Auto deasserted mid-shot completes the current shot, and the block then stays in IDLE.
- Reset at any point: next edge enters IDLE and all outputs take reset values. No Done is issued for the aborted shot.

## Timing
- Reset values: Trigger=0, Busy=0, Done=0, Distance=0, Timeout=0, Near=0. Synchronizer flops reset to 0.
- Start high at edge N (in IDLE): Trigger and Busy high from N+1, Trigger falls at N+1+`TRIG_CYCLES`.
- Done is high for exactly 1 cycle. Distance, Timeout and Near change only in that same cycle.
- Done follows the raw Echo fall by 3 cycles (2 synchronizer cycles + 1 registered).
- Distance = floor(echo_high_cycles / `CYCLES_PER_CM`), saturated at `MAX_CM`; the synchronizer delay cancels on both edges.
- All counters are sized with `$clog2` of their parameter. No arithmetic overflow is possible, because every counter saturates or wraps at its bound.

## Structure
- `hcsr04_pkg`: state encoding and default timing constants for 50 MHz, shared with Trigger and its bench.
- Sub-module `echo_sync`: 2-FF synchronizer with registered level, rise and fall outputs.
- The FSM and counters stay in `hcsr04_ranger`.

## Test plan
All scenarios use sim parameters TRIG_CYCLES=10, CYCLES_PER_CM=58, ECHO_WAIT_CYCLES=2000, COOLDOWN_CYCLES=100, MAX_CM=400, NEAR_CM=20.
- rst=1 for 3 cycles with Echo toggling -> all outputs 0, Busy=0, Trigger never rises.
- Start for 1 cycle, Echo high 1450 cycles after Trigger falls -> Trigger high exactly 10 cycles; single Done with Distance=25, Timeout=0, Near=0.
- Start, Echo held low -> Done exactly 2000 cycles after WAIT_RISE entry; Distance=400, Timeout=1, Near=0.
- Start, Echo high 30000 cycles -> Done after 23200 echo cycles, Distance=400, Timeout=1; IDLE is reached only 100 cycles after Echo falls.
- Auto=1, Echo 580 cycles per shot, Start pulsed while Busy -> Distance=10 and Near=1 every shot; shot spacing is constant; the extra Start causes no extra Trigger.
- rst asserted mid-MEASURE -> no Done; outputs reset; next Start produces a normal 10-cycle Trigger.

Source files
------------

// File: rtl/hcsr04_pkg.sv
// Shared state encoding and 50 MHz default timing constants for the HC-SR04 ranger.
package hcsr04_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_COOLDOWN
  } state_e;

  localparam int unsigned TRIG_CYCLES_50M      = 500;
  localparam int unsigned CYCLES_PER_CM_50M    = 2900;
  localparam int unsigned ECHO_WAIT_CYCLES_50M = 1_500_000;
  localparam int unsigned COOLDOWN_CYCLES_50M  = 3_000_000;
  localparam int unsigned MAX_CM_DEF           = 400;
  localparam int unsigned NEAR_CM_DEF          = 20;
  localparam int unsigned DIST_W_DEF           = 9;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hcsr04_echo_sync.sv
// Two-flop synchronizer for the raw echo pin with level, rise and fall outputs.
// rise_o/fall_o are single-cycle strobes derived from the synchronized level.
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic echo_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, lvl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
    end else begin
      s1_q  <= echo_i;
      s2_q  <= s1_q;
      lvl_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~lvl_q;
  assign fall_o  = ~s2_q & lvl_q;

endmodule

// File: rtl/hcsr04_ranger.sv
// HC-SR04 measurement sequencer: trigger, echo timing in cm, timeout/overrange, cooldown.
// Results appear with a one-cycle Done; Distance/Timeout/Near hold until the next Done.
module hcsr04_ranger
  import hcsr04_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES      = TRIG_CYCLES_50M,
  parameter int unsigned CYCLES_PER_CM    = CYCLES_PER_CM_50M,
  parameter int unsigned ECHO_WAIT_CYCLES = ECHO_WAIT_CYCLES_50M,
  parameter int unsigned COOLDOWN_CYCLES  = COOLDOWN_CYCLES_50M,
  parameter int unsigned MAX_CM           = MAX_CM_DEF,
  parameter int unsigned NEAR_CM          = NEAR_CM_DEF,
  parameter int unsigned DIST_W           = DIST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic              Auto,
  input  logic              Echo,
  output logic              Trigger,
  output logic              Busy,
  output logic              Done,
  output logic [DIST_W-1:0] Distance,
  output logic              Timeout,
  output logic              Near
);

  localparam int unsigned CYC_MAX = max3(TRIG_CYCLES, ECHO_WAIT_CYCLES, COOLDOWN_CYCLES);
  localparam int          CYC_W   = $clog2(CYC_MAX + 1);
  localparam int          SUB_W   = $clog2(CYCLES_PER_CM + 1);

  logic echo_lvl, echo_rise, echo_fall;

  echo_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .echo_i  (Echo),
    .level_o (echo_lvl),
    .rise_o  (echo_rise),
    .fall_o  (echo_fall)
  );

  state_e            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [DIST_W-1:0] cm_q, cm_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              trig_q, done_q, done_d, to_q, to_d, near_q, near_d;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    sub_d   = sub_q;
    cm_d    = cm_q;
    done_d  = 1'b0;
    dist_d  = dist_q;
    to_d    = to_q;
    near_d  = near_q;
    case (state_q)
      ST_IDLE: begin
        cyc_d = '0;
        sub_d = '0;
        cm_d  = '0;
        if (Start | Auto) state_d = ST_TRIG;
      end
      ST_TRIG: begin
        if (cyc_q == CYC_W'(TRIG_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = ST_WAIT_RISE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_WAIT_RISE: begin
        if (echo_rise) begin
          // The rise cycle is itself an echo-high cycle, so it is counted here.
          sub_d   = SUB_W'(1);
          cm_d    = '0;
          state_d = ST_MEASURE;
        end else if (cyc_q == CYC_W'(ECHO_WAIT_CYCLES - 1)) begin
          done_d  = 1'b1;
          dist_d  = DIST_W'(MAX_CM);
          to_d    = 1'b1;
          cyc_d   = '0;
          state_d = ST_COOLDOWN;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_MEASURE: begin
        if (echo_fall) begin
          done_d  = 1'b1;
          dist_d  = cm_q;
          to_d    = 1'b0;
          cyc_d   = '0;
          state_d = ST_COOLDOWN;
        end else if (sub_q == SUB_W'(CYCLES_PER_CM - 1)) begin
          sub_d = '0;
          if (cm_q == DIST_W'(MAX_CM - 1)) begin
            done_d  = 1'b1;
            dist_d  = DIST_W'(MAX_CM);
            to_d    = 1'b1;
            cyc_d   = '0;
            state_d = ST_COOLDOWN;
          end else begin
            cm_d = cm_q + DIST_W'(1);
          end
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
      ST_COOLDOWN: begin
        if (echo_lvl) begin
          cyc_d = '0;
        end else if (cyc_q == CYC_W'(COOLDOWN_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (done_d) near_d = (dist_d < DIST_W'(NEAR_CM)) && !to_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      sub_q   <= '0;
      cm_q    <= '0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      dist_q  <= '0;
      to_q    <= 1'b0;
      near_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      sub_q   <= sub_d;
      cm_q    <= cm_d;
      trig_q  <= (state_d == ST_TRIG);
      done_q  <= done_d;
      dist_q  <= dist_d;
      to_q    <= to_d;
      near_q  <= near_d;
    end
  end

  assign Trigger  = trig_q;
  assign Busy     = (state_q != ST_IDLE);
  assign Done     = done_q;
  assign Distance = dist_q;
  assign Timeout  = to_q;
  assign Near     = near_q;

endmodule

// File: tb/tb_hcsr04_ranger.sv
// Directed and randomized bench for hcsr04_ranger with a cm-arithmetic reference model.
module tb_hcsr04_ranger;

  localparam int TRIG = 10;
  localparam int CPC  = 58;
  localparam int EWC  = 2000;
  localparam int CD   = 100;
  localparam int MAXC = 400;
  localparam int NEAR = 20;
  localparam int DW   = 9;

  logic          clk = 1'b0;
  logic          rst, Start, Auto, Echo;
  logic          Trigger, Busy, Done, Timeout, Near;
  logic [DW-1:0] Distance;

  int pass_cnt = 0, fail_cnt = 0, chk_cnt = 0;
  int cyc_n = 0, done_cnt = 0, trig_rises = 0, done_cyc = 0, busy_fall_cyc = 0;
  int last_dist = 0;
  int last_to = 0, last_near = 0;
  logic trig_prev = 1'b0, busy_prev = 1'b0;

  hcsr04_ranger #(
    .TRIG_CYCLES(TRIG), .CYCLES_PER_CM(CPC), .ECHO_WAIT_CYCLES(EWC),
    .COOLDOWN_CYCLES(CD), .MAX_CM(MAXC), .NEAR_CM(NEAR), .DIST_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .Start(Start), .Auto(Auto), .Echo(Echo),
    .Trigger(Trigger), .Busy(Busy), .Done(Done), .Distance(Distance),
    .Timeout(Timeout), .Near(Near)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n = cyc_n + 1;

  always @(negedge clk) begin
    if (Done === 1'b1) begin
      done_cnt  = done_cnt + 1;
      done_cyc  = cyc_n;
      last_dist = int'(Distance);
      last_to   = int'(Timeout);
      last_near = int'(Near);
    end
    if (Trigger === 1'b1 && trig_prev !== 1'b1) trig_rises = trig_rises + 1;
    if (Busy === 1'b0 && busy_prev === 1'b1) busy_fall_cyc = cyc_n;
    trig_prev = Trigger;
    busy_prev = Busy;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: distance is whole cm of echo time, saturating into overrange.
  function automatic void model(input int h, output int d, output int to, output int nr);
    if (h == 0 || h >= MAXC * CPC) begin
      d  = MAXC;
      to = 1;
    end else begin
      d  = h / CPC;
      to = 0;
    end
    nr = (to == 0 && d < NEAR) ? 1 : 0;
  endfunction

  task automatic wait_trig(input string tag, output int rise_c, output int len, output int fall_c);
    int n = 0;
    while (Trigger !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_trig_seen"}, Trigger, 1);
    check({tag, "_busy_with_trig"}, Busy, 1);
    rise_c = cyc_n;
    len = 0;
    while (Trigger === 1'b1 && len < 1000) begin
      len++;
      @(negedge clk);
    end
    fall_c = cyc_n;
  endtask

  task automatic echo_pulse(input int h, input int dly, output int on_c, output int off_c);
    repeat (dly) @(negedge clk);
    on_c = cyc_n;
    off_c = cyc_n;
    if (h > 0) begin
      Echo = 1'b1;
      repeat (h) @(negedge clk);
      Echo = 1'b0;
      off_c = cyc_n;
    end
  endtask

  task automatic wait_done(input int d0, input int limit);
    int n = 0;
    while (done_cnt <= d0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (Busy !== 1'b0 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, Busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic single(input string tag, input int h, input int dly,
                        output int fall_c, output int on_c, output int off_c);
    int rc, len, d0, ed, et, en;
    d0 = done_cnt;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    wait_trig(tag, rc, len, fall_c);
    check({tag, "_trig_len"}, len, TRIG);
    echo_pulse(h, dly, on_c, off_c);
    wait_done(d0, 3000);
    model(h, ed, et, en);
    check({tag, "_done_count"}, done_cnt - d0, 1);
    check({tag, "_distance"}, last_dist, ed);
    check({tag, "_timeout"}, last_to, et);
    check({tag, "_near"}, last_near, en);
    wait_idle(tag);
  endtask

  initial begin
    int fc, on, off, d0, t0, ed, et, en, len, dd;
    int rc[4];
    int hs[$];

    rst = 1'b1; Start = 1'b0; Auto = 1'b0; Echo = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      Echo = ~Echo;
      check("reset_outputs", {Trigger, Busy, Done, Distance, Timeout, Near}, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    Echo = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_no_trigger", trig_rises, 0);
    check("reset_idle", {Busy, Distance, Timeout, Near}, 0);

    single("basic", 1450, 37, fc, on, off);
    check("basic_done_after_fall", done_cyc - off, 3);

    single("no_echo", 0, 0, fc, on, off);
    check("no_echo_latency", done_cyc - fc, EWC);

    single("overrange", 30000, 12, fc, on, off);
    check("overrange_latency_window",
          ((done_cyc - on) >= MAXC * CPC && (done_cyc - on) <= MAXC * CPC + 3) ? 1 : 0, 1);
    check("overrange_cooldown_window",
          ((busy_fall_cyc - off) >= CD && (busy_fall_cyc - off) <= CD + 3) ? 1 : 0, 1);

    hs = '{1, 57, 58, 1159, 1160, 5800};
    for (int i = 0; i < 5; i++) hs.push_back(int'($urandom_range(1, 2000)));
    foreach (hs[i]) single("rand", hs[i], int'($urandom_range(0, 200)), fc, on, off);

    // Free-running mode with a stray Start mid-shot.
    d0 = done_cnt;
    t0 = trig_rises;
    model(580, ed, et, en);
    Auto = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_trig("auto", rc[i], len, fc);
      check("auto_trig_len", len, TRIG);
      dd = done_cnt;
      @(negedge clk);
      Start = (i == 1);
      @(negedge clk);
      Start = 1'b0;
      echo_pulse(580, 3, on, off);
      if (i == 3) Auto = 1'b0;
      wait_done(dd, 50);
      check("auto_distance", last_dist, ed);
      check("auto_near", last_near, en);
      check("auto_timeout", last_to, et);
    end
    for (int i = 2; i < 4; i++) check("auto_spacing", rc[i] - rc[i-1], rc[1] - rc[0]);
    wait_idle("auto_end");
    repeat (300) @(negedge clk);
    check("auto_trigger_count", trig_rises - t0, 4);
    check("auto_done_count", done_cnt - d0, 4);
    check("auto_stays_idle", Busy, 0);

    // Reset in the middle of a measurement aborts the shot silently.
    d0 = done_cnt;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    wait_trig("abort", rc[0], len, fc);
    repeat (20) @(negedge clk);
    Echo = 1'b1;
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", {Trigger, Busy, Done, Distance, Timeout, Near}, 0);
    rst = 1'b0;
    Echo = 1'b0;
    repeat (50) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle", Busy, 0);
    single("post_reset", 1450, 5, fc, on, off);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
